// File: rtl/delay_pulse_gen.sv
// delay_pulse_gen
// Trigger-to-pulse delay generator. When it sees a rising edge on the
// asynchronous trigger, it waits a programmed number of clock cycles and then
// emits a burst of pulses with a programmed width and gap. The configuration
// is captured when the trigger is accepted, so it may be rewritten while a
// burst is running.
//
// Ports
//   clk         oscillator clock, the only clock
//   rst_n       asynchronous active-low reset
//   trig_in     asynchronous trigger, rising edge is the event
//   abort_in    asynchronous abort, level-sensitive once synchronized
//   delay_cfg   cycles from acceptance to first pulse rise (0 = immediate)
//   width_cfg   pulse high width in cycles (0 treated as 1)
//   gap_cfg     low gap between burst pulses in cycles (0 treated as 1)
//   burst_cfg   pulses per trigger (0 treated as 1)
//   pulse_out   registered output pulse
//   busy        high from acceptance until burst end or abort
//   done        one-cycle strobe at normal burst completion
//   missed_cnt  saturating count of trigger edges ignored while busy

module delay_pulse_gen #(
    parameter int CNT_W       = 16,
    parameter int BURST_W     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trig_in,
    input  logic               abort_in,
    input  logic [CNT_W-1:0]   delay_cfg,
    input  logic [CNT_W-1:0]   width_cfg,
    input  logic [CNT_W-1:0]   gap_cfg,
    input  logic [BURST_W-1:0] burst_cfg,
    output logic               pulse_out,
    output logic               busy,
    output logic               done,
    output logic [7:0]         missed_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        PULSE,
        GAP
    } state_t;

    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

    state_t state;
    state_t state_next;

    logic [SYNC_STAGES-1:0] trig_sync;
    logic [SYNC_STAGES-1:0] abort_sync;
    logic                   trig_hist;
    logic                   abort_hist;
    logic                   rise;
    logic                   abort_act;

    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [CNT_W-1:0]   width_lat;
    logic [CNT_W-1:0]   width_next;
    logic [CNT_W-1:0]   gap_lat;
    logic [CNT_W-1:0]   gap_next;
    logic [BURST_W-1:0] remain;
    logic [BURST_W-1:0] remain_next;
    logic               done_next;

    logic [CNT_W-1:0]   width_eff;
    logic [CNT_W-1:0]   gap_eff;
    logic [BURST_W-1:0] burst_eff;

    // Trigger and abort synchronizers. The extra flop after each chain gives
    // the trigger its edge-detect history and gives the abort one further
    // stage of settling before it acts on the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_sync  <= '0;
            abort_sync <= '0;
            trig_hist  <= 1'b0;
            abort_hist <= 1'b0;
        end else begin
            trig_sync  <= {trig_sync[SYNC_STAGES-2:0], trig_in};
            abort_sync <= {abort_sync[SYNC_STAGES-2:0], abort_in};
            trig_hist  <= trig_sync[SYNC_STAGES-1];
            abort_hist <= abort_sync[SYNC_STAGES-1];
        end
    end

    assign rise      = trig_sync[SYNC_STAGES-1] & ~trig_hist;
    assign abort_act = abort_hist;

    assign width_eff = (width_cfg == '0) ? CNT_ONE   : width_cfg;
    assign gap_eff   = (gap_cfg   == '0) ? CNT_ONE   : gap_cfg;
    assign burst_eff = (burst_cfg == '0) ? BURST_ONE : burst_cfg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            width_lat <= '0;
            gap_lat   <= '0;
            remain    <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            width_lat <= width_next;
            gap_lat   <= gap_next;
            remain    <= remain_next;
            pulse_out <= (state_next == PULSE);
            busy      <= (state_next != IDLE);
            done      <= done_next;
        end
    end

    // Every active state loads its counter with a value of at least 1 and
    // leaves when the counter reads 1, so a count of N holds the state for
    // exactly N cycles.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        width_next  = width_lat;
        gap_next    = gap_lat;
        remain_next = remain;
        done_next   = 1'b0;

        case (state)
            IDLE: begin
                if (rise && !abort_act) begin
                    width_next  = width_eff;
                    gap_next    = gap_eff;
                    remain_next = burst_eff;
                    if (delay_cfg != '0) begin
                        state_next = DELAY;
                        cnt_next   = delay_cfg;
                    end else begin
                        state_next = PULSE;
                        cnt_next   = width_eff;
                    end
                end
            end
            DELAY: begin
                if (cnt == CNT_ONE) begin
                    state_next = PULSE;
                    cnt_next   = width_lat;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            PULSE: begin
                if (cnt == CNT_ONE) begin
                    if (remain > BURST_ONE) begin
                        state_next  = GAP;
                        cnt_next    = gap_lat;
                        remain_next = remain - BURST_ONE;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt == CNT_ONE) begin
                    state_next = PULSE;
                    cnt_next   = width_lat;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort overrides any transition, including a normal completion.
        if ((state != IDLE) && abort_act) begin
            state_next = IDLE;
            done_next  = 1'b0;
        end
    end

    // A trigger edge seen while not idle is dropped. This includes the cycle
    // in which the burst finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            missed_cnt <= 8'd0;
        end else if (rise && (state != IDLE) && (missed_cnt != 8'hFF)) begin
            missed_cnt <= missed_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_delay_pulse_gen.sv
// tb_delay_pulse_gen
// Self-checking bench for delay_pulse_gen. A schedule model predicts the
// outputs on every cycle. Directed scenarios pin the model to hand-computed
// edge numbers, and a randomized phase exercises trigger, abort and
// configuration traffic.

`timescale 1ns/1ps

module tb_delay_pulse_gen;

    localparam int CNT_W   = 16;
    localparam int BURST_W = 8;
    localparam int S       = 2;

    logic               clk;
    logic               rst_n;
    logic               trig_in;
    logic               abort_in;
    logic [CNT_W-1:0]   delay_cfg;
    logic [CNT_W-1:0]   width_cfg;
    logic [CNT_W-1:0]   gap_cfg;
    logic [BURST_W-1:0] burst_cfg;
    logic               pulse_out;
    logic               busy;
    logic               done;
    logic [7:0]         missed_cnt;

    delay_pulse_gen #(
        .CNT_W       (CNT_W),
        .BURST_W     (BURST_W),
        .SYNC_STAGES (S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trig_in    (trig_in),
        .abort_in   (abort_in),
        .delay_cfg  (delay_cfg),
        .width_cfg  (width_cfg),
        .gap_cfg    (gap_cfg),
        .burst_cfg  (burst_cfg),
        .pulse_out  (pulse_out),
        .busy       (busy),
        .done       (done),
        .missed_cnt (missed_cnt)
    );

    // 2.5 MHz oscillator, 400 ns period
    initial clk = 1'b0;
    always #200 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_no = 0;

    always @(posedge clk) edge_no <= edge_no + 1;

    // Behavioural model: a burst is a schedule computed at acceptance time.
    // Pulse i occupies [A+D+i*(W'+G'), A+D+i*(W'+G')+W'), and the burst ends
    // at A+D+(N'-1)*(W'+G')+W' unless the abort cuts it short. The queues
    // hold the recently sampled input levels, newest first.
    bit m_busy, m_pulse, m_done;
    int m_missed, m_e, m_a, m_d, m_w, m_g, m_n, m_end, m_t;
    bit xq[$];
    bit yq[$];
    bit m_rise, m_ab;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   = 1'b0;
            m_pulse  = 1'b0;
            m_done   = 1'b0;
            m_missed = 0;
            xq.delete();
            yq.delete();
            for (int i = 0; i < S + 2; i++) begin
                xq.push_back(1'b0);
                yq.push_back(1'b0);
            end
        end else begin
            m_e++;
            xq.push_front(trig_in);
            yq.push_front(abort_in);
            m_rise = xq[S] && !xq[S+1];
            m_ab   = yq[S+1];
            void'(xq.pop_back());
            void'(yq.pop_back());
            m_done = 1'b0;
            if (m_busy) begin
                if (m_rise && m_missed < 255) m_missed++;
                if (m_ab) begin
                    m_busy = 1'b0;
                end else if (m_e == m_end) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (m_rise && !m_ab) begin
                m_a    = m_e;
                m_d    = int'(delay_cfg);
                m_w    = (width_cfg == '0) ? 1 : int'(width_cfg);
                m_g    = (gap_cfg == '0) ? 1 : int'(gap_cfg);
                m_n    = (burst_cfg == '0) ? 1 : int'(burst_cfg);
                m_end  = m_a + m_d + (m_n - 1) * (m_w + m_g) + m_w;
                m_busy = 1'b1;
            end
            m_pulse = 1'b0;
            if (m_busy) begin
                m_t = m_e - m_a - m_d;
                if (m_t >= 0 && (m_t % (m_w + m_g)) < m_w) m_pulse = 1'b1;
            end
        end
    end

    // Edge numbers at which the DUT outputs changed, for directed checks
    int pulse_rises[$];
    int pulse_falls[$];
    int done_edges[$];
    int busy_rises[$];
    int busy_falls[$];
    logic prev_pulse, prev_busy;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual %0d required %0d at edge %0d", name, actual, expected, edge_no);
        end
    endtask

    function automatic int qAt(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic compareLoop();
        prev_pulse = 1'b0;
        prev_busy  = 1'b0;
        forever begin
            @(negedge clk);
            checkOutput("pulse_out", int'(pulse_out), int'(m_pulse));
            checkOutput("busy", int'(busy), int'(m_busy));
            checkOutput("done", int'(done), int'(m_done));
            checkOutput("missed_cnt", int'(missed_cnt), m_missed);
            if (pulse_out && !prev_pulse) pulse_rises.push_back(edge_no);
            if (!pulse_out && prev_pulse) pulse_falls.push_back(edge_no);
            if (busy && !prev_busy) busy_rises.push_back(edge_no);
            if (!busy && prev_busy) busy_falls.push_back(edge_no);
            if (done) done_edges.push_back(edge_no);
            prev_pulse = pulse_out;
            prev_busy  = busy;
        end
    endtask

    task automatic clearEvents();
        pulse_rises.delete();
        pulse_falls.delete();
        done_edges.delete();
        busy_rises.delete();
        busy_falls.delete();
    endtask

    // Set the config and raise trig_in for one cycle. k is the edge that
    // samples trig_in high. The task returns just after edge k.
    task automatic applyStimulus(input int d, input int w, input int g, input int n, output int k);
        @(negedge clk);
        delay_cfg = CNT_W'(d);
        width_cfg = CNT_W'(w);
        gap_cfg   = CNT_W'(g);
        burst_cfg = BURST_W'(n);
        trig_in   = 1'b1;
        k = edge_no + 1;
        @(negedge clk);
        trig_in = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        repeat (4) @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic randCfg();
        delay_cfg = CNT_W'($urandom_range(0, 12));
        width_cfg = CNT_W'($urandom_range(0, 4));
        gap_cfg   = CNT_W'($urandom_range(0, 4));
        burst_cfg = BURST_W'($urandom_range(0, 4));
    endtask

    task automatic scenarioBasic(input string tag);
        int k;
        clearEvents();
        applyStimulus(5, 3, 0, 1, k);
        waitIdle(100);
        checkOutput({tag, "_busy_rise"}, qAt(busy_rises, 0), k + 2);
        checkOutput({tag, "_pulse_rise"}, qAt(pulse_rises, 0), k + 7);
        checkOutput({tag, "_pulse_fall"}, qAt(pulse_falls, 0), k + 10);
        checkOutput({tag, "_done_edge"}, qAt(done_edges, 0), k + 10);
        checkOutput({tag, "_done_count"}, done_edges.size(), 1);
    endtask

    int k;
    int hold;
    int gap_cycles;
    int budget;

    initial begin
        rst_n     = 1'b0;
        trig_in   = 1'b0;
        abort_in  = 1'b0;
        delay_cfg = '0;
        width_cfg = '0;
        gap_cfg   = '0;
        burst_cfg = '0;
        fork
            compareLoop();
        join_none
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_pulse", int'(pulse_out), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_missed", int'(missed_cnt), 0);

        // D=5 W=3 N=1
        scenarioBasic("s1");

        // All-zero config: single one-cycle pulse at acceptance
        clearEvents();
        applyStimulus(0, 0, 0, 0, k);
        waitIdle(100);
        checkOutput("s2_pulse_rise", qAt(pulse_rises, 0), k + 2);
        checkOutput("s2_pulse_fall", qAt(pulse_falls, 0), k + 3);
        checkOutput("s2_done_edge", qAt(done_edges, 0), k + 3);
        checkOutput("s2_pulse_count", pulse_rises.size(), 1);

        // D=2 W=2 G=4 N=3 with a second trigger during the burst
        clearEvents();
        applyStimulus(2, 2, 4, 3, k);
        @(negedge clk);
        @(negedge clk);
        trig_in = 1'b1;
        @(negedge clk);
        trig_in = 1'b0;
        waitIdle(100);
        checkOutput("s3_rise0", qAt(pulse_rises, 0), k + 4);
        checkOutput("s3_rise1", qAt(pulse_rises, 1), k + 10);
        checkOutput("s3_rise2", qAt(pulse_rises, 2), k + 16);
        checkOutput("s3_fall2", qAt(pulse_falls, 2), k + 18);
        checkOutput("s3_pulse_count", pulse_rises.size(), 3);
        checkOutput("s3_done_edge", qAt(done_edges, 0), k + 18);
        checkOutput("s3_done_count", done_edges.size(), 1);
        checkOutput("s3_missed", int'(missed_cnt), 1);

        // Abort sampled at A+9 during the N=3 burst
        clearEvents();
        applyStimulus(2, 2, 4, 3, k);
        repeat (10) @(negedge clk);
        abort_in = 1'b1;
        repeat (2) @(negedge clk);
        abort_in = 1'b0;
        waitIdle(100);
        checkOutput("s4_busy_fall", qAt(busy_falls, 0), k + 14);
        checkOutput("s4_pulse_count", pulse_rises.size(), 2);
        checkOutput("s4_done_count", done_edges.size(), 0);
        scenarioBasic("s4_after");

        // Missed-trigger saturation during a long delay
        applyStimulus(1000, 1, 1, 1, k);
        repeat (300) begin
            @(negedge clk);
            trig_in = 1'b1;
            @(negedge clk);
            trig_in = 1'b0;
        end
        repeat (4) @(negedge clk);
        checkOutput("s5_missed_sat", int'(missed_cnt), 255);
        checkOutput("s5_still_busy", int'(busy), 1);
        abort_in = 1'b1;
        repeat (3) @(negedge clk);
        abort_in = 1'b0;
        waitIdle(100);

        // Asynchronous reset in the middle of a pulse
        applyStimulus(5, 20, 0, 1, k);
        budget = 0;
        while (!pulse_out && budget < 30) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("s6_pulse_seen", int'(pulse_out), 1);
        @(posedge clk);
        #50;
        rst_n = 1'b0;
        #1;
        checkOutput("s6_async_pulse", int'(pulse_out), 0);
        checkOutput("s6_async_busy", int'(busy), 0);
        checkOutput("s6_async_done", int'(done), 0);
        checkOutput("s6_async_missed", int'(missed_cnt), 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        scenarioBasic("s6_after");

        // Randomized traffic: overlapping triggers, aborts, config rewrites
        for (int it = 0; it < 150; it++) begin
            @(negedge clk);
            randCfg();
            trig_in = 1'b1;
            hold = $urandom_range(1, 3);
            repeat (hold) @(negedge clk);
            trig_in = 1'b0;
            gap_cycles = $urandom_range(1, 40);
            for (int c = 0; c < gap_cycles; c++) begin
                @(negedge clk);
                if ($urandom_range(0, 9) == 0) randCfg();
                if ($urandom_range(0, 59) == 0) abort_in = 1'b1;
                else if (abort_in && $urandom_range(0, 2) == 0) abort_in = 1'b0;
            end
        end
        abort_in = 1'b0;
        waitIdle(2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
